// File: rtl/ss_pkg.sv
// Shared types and constants for the return-address shadow-stack checker.
package ss_pkg;

    typedef enum logic {IDLE, SWAP_PUSH} ss_state_e;

    // Link offset for compressed and standard-length calls.
    localparam int unsigned LINK_INC_RVC = 2;
    localparam int unsigned LINK_INC_STD = 4;

    // Width of the logged violation record fields.
    localparam int unsigned SS_XLEN = 64;

    typedef struct packed {
        logic [SS_XLEN-1:0] pc;
        logic [SS_XLEN-1:0] expected;
        logic [SS_XLEN-1:0] actual;
    } viol_rec_t;

endpackage

// File: rtl/ss_viol_log.sv
// Sticky violation flag with first-violation capture.
module ss_viol_log
    import ss_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set_i,
    input  logic      clr_i,
    input  viol_rec_t rec_i,
    output logic      sticky_o,
    output viol_rec_t rec_o
);

    logic      sticky_q, sticky_d;
    viol_rec_t rec_q, rec_d;

    // Set beats clear; the record only loads when no earlier violation is held.
    always_comb begin
        sticky_d = sticky_q;
        rec_d    = rec_q;
        if (clr_i) begin
            sticky_d = 1'b0;
        end
        if (set_i) begin
            sticky_d = 1'b1;
            if (!sticky_q || clr_i) begin
                rec_d = rec_i;
            end
        end
    end

    // Flag and record registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
            rec_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            rec_q    <= rec_d;
        end
    end

    assign sticky_o = sticky_q;
    assign rec_o    = rec_q;

endmodule

// File: rtl/ss_cfi_checker.sv
// Commit-side front end of the return-address shadow stack: pushes call links,
// pops and checks return targets, and logs control-flow violations.
module ss_cfi_checker
    import ss_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned CNT_W        = 32,
    parameter bit          HALT_ON_VIOL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             cmt_valid,
    output logic             cmt_ready,
    input  logic [XLEN-1:0]  cmt_pc,
    input  logic [XLEN-1:0]  cmt_target,
    input  logic             cmt_is_call,
    input  logic             cmt_is_ret,
    input  logic             cmt_rvc,
    output logic             ss_push,
    output logic [XLEN-1:0]  ss_wdata,
    output logic             ss_pop,
    input  logic [XLEN-1:0]  ss_rdata,
    input  logic             ss_empty,
    input  logic             ss_usable,
    input  logic             viol_clr,
    output logic             viol_pulse,
    output logic             viol_sticky,
    output logic [XLEN-1:0]  viol_pc,
    output logic [XLEN-1:0]  viol_expected,
    output logic [XLEN-1:0]  viol_actual,
    output logic [CNT_W-1:0] cnt_call,
    output logic [CNT_W-1:0] cnt_ret_chk,
    output logic [CNT_W-1:0] cnt_ret_skip
);

    ss_state_e        state_q, state_d;
    logic [XLEN-1:0]  link_q, link_d, link_sum;
    logic             accept, mismatch;
    logic             inc_call, inc_chk, inc_skip;
    logic             pulse_q, pulse_d;
    viol_rec_t        rec_q, rec_d, log_rec;
    logic             sticky;
    logic [CNT_W-1:0] cnt_call_q, cnt_chk_q, cnt_skip_q;

    assign link_sum = cmt_pc + (cmt_rvc ? XLEN'(LINK_INC_RVC) : XLEN'(LINK_INC_STD));
    assign mismatch = (ss_rdata != cmt_target);

    // Ready is state-based only so the accept decode below stays acyclic.
    assign cmt_ready = rst | ((state_q == IDLE) & ~(HALT_ON_VIOL & sticky));
    assign accept    = cmt_valid & cmt_ready;

    // Next-state, stack strobes and counter increments.
    always_comb begin
        state_d  = state_q;
        link_d   = link_q;
        ss_push  = 1'b0;
        ss_pop   = 1'b0;
        ss_wdata = '0;
        inc_call = 1'b0;
        inc_chk  = 1'b0;
        inc_skip = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (accept && i_en) begin
                        if (cmt_is_ret) begin
                            // An overflowed stack still pops to keep its depth count coherent.
                            ss_pop = ~ss_empty;
                            if (!ss_empty && ss_usable) begin
                                inc_chk = 1'b1;
                            end else begin
                                inc_skip = 1'b1;
                            end
                            if (cmt_is_call) begin
                                link_d  = link_sum;
                                state_d = SWAP_PUSH;
                            end
                        end else if (cmt_is_call) begin
                            ss_push  = 1'b1;
                            ss_wdata = link_sum;
                            inc_call = 1'b1;
                        end
                    end
                end
                SWAP_PUSH: begin
                    // Completes regardless of i_en.
                    ss_push  = 1'b1;
                    ss_wdata = link_q;
                    inc_call = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Compare result and the record that goes with it.
    always_comb begin
        pulse_d = inc_chk & mismatch;
        rec_d   = rec_q;
        if (pulse_d) begin
            rec_d.pc       = SS_XLEN'(cmt_pc);
            rec_d.expected = SS_XLEN'(ss_rdata);
            rec_d.actual   = SS_XLEN'(cmt_target);
        end
    end

    // FSM, latched link and registered compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            link_q  <= '0;
            pulse_q <= 1'b0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            link_q  <= link_d;
            pulse_q <= pulse_d;
            rec_q   <= rec_d;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_call_q <= '0;
            cnt_chk_q  <= '0;
            cnt_skip_q <= '0;
        end else begin
            if (inc_call && cnt_call_q != '1) cnt_call_q <= cnt_call_q + 1'b1;
            if (inc_chk  && cnt_chk_q  != '1) cnt_chk_q  <= cnt_chk_q  + 1'b1;
            if (inc_skip && cnt_skip_q != '1) cnt_skip_q <= cnt_skip_q + 1'b1;
        end
    end

    ss_viol_log u_log (
        .clk      (clk),
        .rst      (rst),
        .set_i    (pulse_q),
        .clr_i    (viol_clr),
        .rec_i    (rec_q),
        .sticky_o (sticky),
        .rec_o    (log_rec)
    );

    assign viol_pulse    = pulse_q;
    assign viol_sticky   = sticky;
    assign viol_pc       = XLEN'(log_rec.pc);
    assign viol_expected = XLEN'(log_rec.expected);
    assign viol_actual   = XLEN'(log_rec.actual);
    assign cnt_call      = cnt_call_q;
    assign cnt_ret_chk   = cnt_chk_q;
    assign cnt_ret_skip  = cnt_skip_q;

endmodule
